// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry, the zero register, and word types.
package cpu_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NREGS      = 32;
  localparam int unsigned WORD_W     = 64;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t XZR = 5'd31;

  // True when an address names a real storage entry rather than XZR.
  function automatic logic is_storage_addr(input reg_addr_t addr);
    return addr != XZR;
  endfunction

endpackage : cpu_pkg

// File: rtl/mux32_1.sv
// WIDTH-wide 32:1 combinational read mux selected by a register address.
module mux32_1
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] d [32],
  input  reg_addr_t        sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d[sel];
  end

endmodule : mux32_1

// File: rtl/register.sv
// Enabled flip-flop register with synchronous active-high clear.
module register #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d;
    end
  end

  // Clear wins over the enable so a write in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule : register

// File: rtl/regfile.sv
// LEGv8 integer register file: X0-X30 in storage, X31 reads zero, two async
// read ports with write-through bypass and one synchronous write port.
module regfile
  import cpu_pkg::XZR;
  import cpu_pkg::is_storage_addr;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned NREGS = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     RegWrite,
  input  logic [$clog2(NREGS)-1:0] WriteRegister,
  input  logic [WIDTH-1:0]         WriteData,
  input  logic [$clog2(NREGS)-1:0] ReadRegister1,
  input  logic [$clog2(NREGS)-1:0] ReadRegister2,
  output logic [WIDTH-1:0]         ReadData1,
  output logic [WIDTH-1:0]         ReadData2
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [NREGS-2:0] wr_en_c;
  logic [WIDTH-1:0] entries [NREGS];
  logic [WIDTH-1:0] mux1_c;
  logic [WIDTH-1:0] mux2_c;
  logic [WIDTH-1:0] rd1_c;
  logic [WIDTH-1:0] rd2_c;

  // One-hot write decode; XZR has no entry so its decode line never exists.
  always_comb begin
    wr_en_c = '0;
    for (int unsigned i = 0; i < NREGS - 1; i++) begin
      wr_en_c[i] = RegWrite && (WriteRegister == AW'(i));
    end
  end

  for (genvar g = 0; g < NREGS - 1; g++) begin : g_entry
    register #(
      .WIDTH (WIDTH)
    ) u_reg (
      .clk   (clk),
      .reset (reset),
      .en    (wr_en_c[g]),
      .d     (WriteData),
      .q     (entries[g])
    );
  end

  assign entries[NREGS-1] = '0;

  mux32_1 #(
    .WIDTH (WIDTH)
  ) u_mux1 (
    .d   (entries),
    .sel (ReadRegister1),
    .y   (mux1_c)
  );

  mux32_1 #(
    .WIDTH (WIDTH)
  ) u_mux2 (
    .d   (entries),
    .sel (ReadRegister2),
    .y   (mux2_c)
  );

  // Bypass is deliberately not gated by reset; XZR always beats the bypass.
  always_comb begin
    rd1_c = mux1_c;
    rd2_c = mux2_c;
    if (RegWrite && (WriteRegister == ReadRegister1) && is_storage_addr(ReadRegister1)) begin
      rd1_c = WriteData;
    end
    if (RegWrite && (WriteRegister == ReadRegister2) && is_storage_addr(ReadRegister2)) begin
      rd2_c = WriteData;
    end
  end

  assign ReadData1 = rd1_c;
  assign ReadData2 = rd2_c;

endmodule : regfile
